// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic light controller.
// State encodings, lamp codes, selector codes and duration rules.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        WALK    = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_GX = 3'd4,
        SIDE_Y  = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;

    // A programmed zero still yields a one-second state.
    function automatic logic [4:0] secs(input logic [3:0] v);
        return (v == 4'd0) ? 5'd1 : {1'b0, v};
    endfunction

    function automatic logic [4:0] state_dur(
        input state_t     s,
        input logic [3:0] base,
        input logic [3:0] ext,
        input logic [3:0] yel
    );
        logic [4:0] d;
        d = secs(base);
        case (s)
            MAIN_G:          d = secs(base) << 1;
            MAIN_Y, SIDE_Y:  d = secs(yel);
            WALK, SIDE_GX:   d = secs(ext);
            default:         d = secs(base);
        endcase
        return d;
    endfunction

    // Packed as {main, side, walk}.
    function automatic logic [6:0] lamps(input state_t s);
        logic [6:0] l;
        l = {GRN, RED, 1'b0};
        case (s)
            MAIN_G:          l = {GRN, RED, 1'b0};
            MAIN_Y:          l = {YEL, RED, 1'b0};
            WALK:            l = {RED, RED, 1'b1};
            SIDE_G, SIDE_GX: l = {RED, GRN, 1'b0};
            SIDE_Y:          l = {RED, YEL, 1'b0};
            default:         l = {GRN, RED, 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Clock prescaler producing a one-second tick, plus a loadable
// seconds down-counter that flags its final second.
module sec_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter logic [4:0]  INIT_LEFT     = 5'd12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [4:0] load_value,
    output logic       tick,
    output logic       expire,
    output logic [4:0] remaining
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] count;

    assign tick   = (count == TERM);
    assign expire = (remaining == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            remaining <= INIT_LEFT;
        end else begin
            if (clear || tick)
                count <= '0;
            else
                count <= count + 1'b1;
            if (load)
                remaining <= load_value;
            else if (tick && remaining > 5'd1)
                remaining <= remaining - 5'd1;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Moore traffic light sequencer with walk latch and programmable
// base/extended/yellow intervals; all outputs are registered.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter logic [3:0]  DEF_BASE      = 4'd6,
    parameter logic [3:0]  DEF_EXT       = 4'd3,
    parameter logic [3:0]  DEF_YEL       = 4'd2
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       traffic_sensor,
    input  logic       walk_request,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light,
    output logic [4:0] time_remaining
);

    localparam logic [4:0] INIT_LEFT = secs(DEF_BASE) << 1;

    state_t     state, state_n;
    logic [3:0] t_base, t_ext, t_yel;
    logic [3:0] base_n, ext_n, yel_n;
    logic       walk_q, prog_q;
    logic       walk_pending, pend_n;
    logic       walk_rise, prog_rise;
    logic       tick, expire, timeout;
    logic       load;
    logic [4:0] load_value;
    logic [6:0] lights_n;

    assign walk_rise = walk_request & ~walk_q;
    assign prog_rise = reprogram & ~prog_q;
    assign timeout   = tick & expire;

    sec_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .INIT_LEFT     (INIT_LEFT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (global_reset_n),
        .clear      (prog_rise),
        .load       (load),
        .load_value (load_value),
        .tick       (tick),
        .expire     (expire),
        .remaining  (time_remaining)
    );

    always_comb begin
        state_n    = state;
        base_n     = t_base;
        ext_n      = t_ext;
        yel_n      = t_yel;
        pend_n     = walk_pending;
        load       = 1'b0;
        load_value = time_remaining;
        if (prog_rise) begin
            // Restart overrides any tick or expiry this cycle.
            case (time_param_sel)
                SEL_BASE: base_n = time_value;
                SEL_EXT:  ext_n  = time_value;
                SEL_YEL:  yel_n  = time_value;
                default:  ;
            endcase
            state_n    = MAIN_G;
            pend_n     = 1'b0;
            load       = 1'b1;
            load_value = state_dur(MAIN_G, base_n, ext_n, yel_n);
        end else begin
            if (walk_rise && state != WALK)
                pend_n = 1'b1;
            if (timeout) begin
                unique case (state)
                    MAIN_G:  state_n = MAIN_Y;
                    MAIN_Y:  state_n = walk_pending ? WALK : SIDE_G;
                    WALK:    state_n = SIDE_G;
                    SIDE_G:  state_n = traffic_sensor ? SIDE_GX : SIDE_Y;
                    SIDE_GX: state_n = SIDE_Y;
                    SIDE_Y:  state_n = MAIN_G;
                    default: state_n = MAIN_G;
                endcase
                if (state_n == WALK)
                    pend_n = 1'b0;
                load       = 1'b1;
                load_value = state_dur(state_n, t_base, t_ext, t_yel);
            end
        end
        lights_n = lamps(state_n);
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state        <= MAIN_G;
            t_base       <= DEF_BASE;
            t_ext        <= DEF_EXT;
            t_yel        <= DEF_YEL;
            walk_q       <= 1'b0;
            prog_q       <= 1'b0;
            walk_pending <= 1'b0;
            main_light   <= GRN;
            side_light   <= RED;
            walk_light   <= 1'b0;
        end else begin
            state        <= state_n;
            t_base       <= base_n;
            t_ext        <= ext_n;
            t_yel        <= yel_n;
            walk_q       <= walk_request;
            prog_q       <= reprogram;
            walk_pending <= pend_n;
            main_light   <= lights_n[6:4];
            side_light   <= lights_n[3:1];
            walk_light   <= lights_n[0];
        end
    end

    a_no_conflict: assert property (
        @(posedge clk) disable iff (!global_reset_n)
        (main_light == RED) || (side_light == RED)
    );

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scenario bench for traffic_light_controller with a cycle-level
// phase/seconds reference model and randomized stress phase.
module tb_traffic_light_controller;

    localparam int TPS = 4;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       global_reset_n;
    logic       traffic_sensor;
    logic       walk_request;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;
    logic [4:0] time_remaining;

    traffic_light_controller #(.TICKS_PER_SEC(TPS)) dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .traffic_sensor (traffic_sensor),
        .walk_request   (walk_request),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .main_light     (main_light),
        .side_light     (side_light),
        .walk_light     (walk_light),
        .time_remaining (time_remaining)
    );

    always #5 clk = ~clk;

    typedef enum int {
        P_MAIN_G, P_MAIN_Y, P_WALK, P_SIDE_G, P_SIDE_GX, P_SIDE_Y
    } phase_t;

    logic [2:0] exp_main [6] = '{G, Y, R, R, R, R};
    logic [2:0] exp_side [6] = '{R, R, R, G, G, Y};
    logic       exp_walk [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    phase_t m_ph;
    int     m_cnt, m_left, m_base, m_ext, m_yel;
    bit     m_pend, m_wprev, m_pprev;

    function automatic int mx(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int m_len(input phase_t p);
        case (p)
            P_MAIN_G:            return 2 * mx(m_base);
            P_MAIN_Y, P_SIDE_Y:  return mx(m_yel);
            P_WALK, P_SIDE_GX:   return mx(m_ext);
            default:             return mx(m_base);
        endcase
    endfunction

    task automatic m_reset();
        m_ph    = P_MAIN_G;
        m_cnt   = 0;
        m_base  = 6;
        m_ext   = 3;
        m_yel   = 2;
        m_pend  = 0;
        m_wprev = 0;
        m_pprev = 0;
        m_left  = m_len(P_MAIN_G);
    endtask

    // One clock of the reference, using inputs as seen at the edge.
    task automatic m_step();
        bit     pe, we, tk;
        phase_t nx;
        pe = reprogram && !m_pprev;
        we = walk_request && !m_wprev;
        m_pprev = reprogram;
        m_wprev = walk_request;
        if (pe) begin
            case (time_param_sel)
                2'd0: m_base = int'(time_value);
                2'd1: m_ext  = int'(time_value);
                2'd2: m_yel  = int'(time_value);
                default: ;
            endcase
            m_ph   = P_MAIN_G;
            m_cnt  = 0;
            m_pend = 0;
            m_left = m_len(P_MAIN_G);
            return;
        end
        tk    = (m_cnt == TPS - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (we && m_ph != P_WALK) m_pend = 1;
        if (tk) begin
            if (m_left > 1) m_left--;
            else begin
                case (m_ph)
                    P_MAIN_G:  nx = P_MAIN_Y;
                    P_MAIN_Y:  nx = m_pend ? P_WALK : P_SIDE_G;
                    P_WALK:    nx = P_SIDE_G;
                    P_SIDE_G:  nx = traffic_sensor ? P_SIDE_GX : P_SIDE_Y;
                    P_SIDE_GX: nx = P_SIDE_Y;
                    default:   nx = P_MAIN_G;
                endcase
                m_ph   = nx;
                m_left = m_len(nx);
                if (nx == P_WALK) m_pend = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic run_len(output int n);
        logic [6:0] cur;
        cur = {main_light, side_light, walk_light};
        n = 0;
        while ({main_light, side_light, walk_light} == cur && n < 400) begin
            n++;
            cycle();
        end
    endtask

    // which: 0 = main, 1 = side, 2 = walk
    task automatic wait_for(input int which, input logic [2:0] v,
                            input string nm);
        int n;
        logic [2:0] cur;
        n = 0;
        forever begin
            cur = (which == 0) ? main_light :
                  (which == 1) ? side_light : {2'b00, walk_light};
            if (cur == v || n >= 400) break;
            n++;
            cycle();
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_%s: timed out, saw %b want %b", nm, cur, v);
        end
    endtask

    task automatic pulse_prog(input logic [1:0] sel, input logic [3:0] val);
        time_param_sel = sel;
        time_value     = val;
        reprogram      = 1'b1;
        cycle();
        reprogram      = 1'b0;
    endtask

    task automatic test_reset();
        global_reset_n = 1'b0;
        traffic_sensor = 1'b0;
        walk_request   = 1'b0;
        reprogram      = 1'b0;
        time_param_sel = 2'd3;
        time_value     = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({main_light, side_light, walk_light} !== {G, R, 1'b0}) begin
            errors++;
            $display("FAIL reset_lights: got %b/%b/%b want 001/100/0",
                     main_light, side_light, walk_light);
        end
        checks++;
        if (time_remaining !== 5'd12) begin
            errors++;
            $display("FAIL reset_time: got %0d want 12", time_remaining);
        end
        global_reset_n = 1'b1;
        m_reset();
    endtask

    task automatic test_free_run();
        int n;
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (time_remaining !== 5'(12 - i / 4)) begin
                errors++;
                $display("FAIL main_countdown[%0d]: got %0d want %0d",
                         i, time_remaining, 12 - i / 4);
            end
            cycle();
        end
        checks++;
        if (main_light !== Y || side_light !== R) begin
            errors++;
            $display("FAIL enter_main_y: got %b/%b", main_light, side_light);
        end
        run_len(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL main_y_len: got %0d want 8", n);
        end
        checks++;
        if (side_light !== G || walk_light !== 1'b0) begin
            errors++;
            $display("FAIL enter_side_g: got %b walk %b", side_light, walk_light);
        end
        run_len(n);
        checks++;
        if (n != 24) begin
            errors++;
            $display("FAIL side_g_len: got %0d want 24", n);
        end
        run_len(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL side_y_len: got %0d want 8", n);
        end
        checks++;
        if (main_light !== G || time_remaining !== 5'd12) begin
            errors++;
            $display("FAIL back_to_main: got %b time %0d", main_light, time_remaining);
        end
        run_len(n);
        checks++;
        if (n != 48) begin
            errors++;
            $display("FAIL main_g_len: got %0d want 48", n);
        end
    endtask

    task automatic test_walk();
        int n;
        wait_for(1, G, "side_g");
        walk_request = 1'b1;
        cycle();
        walk_request = 1'b0;
        wait_for(0, Y, "main_y");
        run_len(n);
        checks++;
        if ({main_light, side_light, walk_light} !== {R, R, 1'b1}) begin
            errors++;
            $display("FAIL walk_lights: got %b/%b/%b want 100/100/1",
                     main_light, side_light, walk_light);
        end
        run_len(n);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL walk_len: got %0d want 12", n);
        end
        wait_for(0, Y, "main_y2");
        run_len(n);
        checks++;
        if (walk_light !== 1'b0 || side_light !== G) begin
            errors++;
            $display("FAIL walk_cleared: walk %b side %b want 0/001",
                     walk_light, side_light);
        end
    endtask

    task automatic test_sensor();
        int n;
        wait_for(1, G, "side_g");
        traffic_sensor = 1'b1;
        repeat (24) cycle();
        checks++;
        if (side_light !== G || time_remaining !== 5'd3) begin
            errors++;
            $display("FAIL enter_side_gx: side %b time %0d want 001/3",
                     side_light, time_remaining);
        end
        run_len(n);
        checks++;
        if (n != 12 || side_light !== Y) begin
            errors++;
            $display("FAIL side_gx_len: got %0d side %b want 12/010", n, side_light);
        end
        traffic_sensor = 1'b0;
        wait_for(1, G, "side_g2");
        run_len(n);
        checks++;
        if (n != 24 || side_light !== Y) begin
            errors++;
            $display("FAIL no_sensor: got %0d side %b want 24/010", n, side_light);
        end
    endtask

    task automatic test_reprogram();
        int n;
        wait_for(1, G, "side_g");
        repeat (5) cycle();
        pulse_prog(2'd0, 4'd2);
        checks++;
        if (main_light !== G || side_light !== R || time_remaining !== 5'd4) begin
            errors++;
            $display("FAIL prog_base: got %b/%b time %0d want 001/100/4",
                     main_light, side_light, time_remaining);
        end
        run_len(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL prog_main_len: got %0d want 16", n);
        end
        cycle();
        pulse_prog(2'd2, 4'd0);
        run_len(n);
        run_len(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL prog_yel_len: got %0d want 4", n);
        end
    endtask

    task automatic test_coincident();
        int n;
        wait_for(0, G, "main_g");
        pulse_prog(2'd3, 4'd9);
        checks++;
        if (time_remaining !== 5'd4) begin
            errors++;
            $display("FAIL sel3_time: got %0d want 4", time_remaining);
        end
        wait_for(0, Y, "main_y");
        n = 0;
        while (!(m_cnt == TPS - 1 && m_left == 1) && n < 400) begin
            n++;
            cycle();
        end
        pulse_prog(2'd3, 4'd7);
        checks++;
        if (main_light !== G || side_light !== R || time_remaining !== 5'd4) begin
            errors++;
            $display("FAIL prog_at_expiry: got %b/%b time %0d want 001/100/4",
                     main_light, side_light, time_remaining);
        end
        run_len(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL sel3_main_len: got %0d want 16", n);
        end
        run_len(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL sel3_yel_len: got %0d want 4", n);
        end
        cycle();
        pulse_prog(2'd0, 4'd6);
        cycle();
        pulse_prog(2'd2, 4'd2);
    endtask

    task automatic test_async_reset();
        int n;
        wait_for(1, G, "side_g");
        walk_request = 1'b1;
        cycle();
        walk_request = 1'b0;
        wait_for(2, 3'b001, "walk");
        cycle();
        cycle();
        #2 global_reset_n = 1'b0;
        #1;
        checks++;
        if ({main_light, side_light, walk_light} !== {G, R, 1'b0}
            || time_remaining !== 5'd12) begin
            errors++;
            $display("FAIL async_reset: got %b/%b/%b time %0d want 001/100/0/12",
                     main_light, side_light, walk_light, time_remaining);
        end
        @(posedge clk);
        @(negedge clk);
        global_reset_n = 1'b1;
        m_reset();
        run_len(n);
        checks++;
        if (n != 48) begin
            errors++;
            $display("FAIL post_reset_main_len: got %0d want 48", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            walk_request   = ($urandom_range(0, 7) == 0);
            reprogram      = ($urandom_range(0, 59) == 0);
            time_param_sel = 2'($urandom_range(0, 3));
            time_value     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) traffic_sensor = ~traffic_sensor;
            cycle();
            checks++;
            if (main_light !== exp_main[m_ph] || side_light !== exp_side[m_ph]
                || walk_light !== exp_walk[m_ph]) begin
                errors++;
                $display("FAIL rand_lights[%0d]: got %b/%b/%b want %b/%b/%b", i,
                         main_light, side_light, walk_light,
                         exp_main[m_ph], exp_side[m_ph], exp_walk[m_ph]);
            end
            checks++;
            if (time_remaining !== 5'(m_left)) begin
                errors++;
                $display("FAIL rand_time[%0d]: got %0d want %0d",
                         i, time_remaining, m_left);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_walk();
        test_sensor();
        test_reprogram();
        test_coincident();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
